dcache_rr_arbiter: RTL and testbench

//  N-port round-robin arbiter in front of the single DCache request port; successor to the fixed 2-port rd/wr arbiter.

---
 rtl/dcache_rr_arbiter_if.sv | 46 ++++
 rtl/dcache_rr_arbiter.sv | 154 +++++++++++++++
 tb/tb_dcache_rr_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_rr_arbiter_if.sv
// Request/response bundle between the requesting ports, the arbiter and the DCache.
// The slave view is the arbiter; the master view is the requesters plus the DCache.
interface dcache_rr_arbiter_if #(
   parameter int NUM_PORTS = 4,
   parameter int PADDR_W   = 56,
   parameter int DATA_W    = 64,
   parameter int DT_W      = 3
);
   localparam int GNT_W = $clog2(NUM_PORTS);

   logic [NUM_PORTS-1:0]         port_valid;
   logic [NUM_PORTS-1:0]         port_wr;
   logic [NUM_PORTS*DT_W-1:0]    port_datatype;
   logic [NUM_PORTS*PADDR_W-1:0] port_paddr;
   logic [NUM_PORTS*DATA_W-1:0]  port_wrdata;
   logic [NUM_PORTS-1:0]         port_abort;
   logic [NUM_PORTS-1:0]         port_done;
   logic [NUM_PORTS-1:0]         port_ready;
   logic [DATA_W-1:0]            port_rddata;
   logic                         dc_req_valid;
   logic                         dc_req_type;
   logic [DT_W-1:0]              dc_req_datatype;
   logic [PADDR_W-1:0]           dc_req_paddr;
   logic [DATA_W-1:0]            dc_req_wrdata;
   logic                         dc_req_rdabort;
   logic                         dc_resp_done;
   logic                         dc_resp_ready;
   logic [DATA_W-1:0]            dc_resp_rddata;
   logic [GNT_W-1:0]             arb_gnt_id;

   modport master (
      output port_valid, port_wr, port_datatype, port_paddr, port_wrdata, port_abort,
      output dc_resp_done, dc_resp_ready, dc_resp_rddata,
      input  port_done, port_ready, port_rddata,
      input  dc_req_valid, dc_req_type, dc_req_datatype, dc_req_paddr, dc_req_wrdata,
      input  dc_req_rdabort, arb_gnt_id
   );

   modport slave (
      input  port_valid, port_wr, port_datatype, port_paddr, port_wrdata, port_abort,
      input  dc_resp_done, dc_resp_ready, dc_resp_rddata,
      output port_done, port_ready, port_rddata,
      output dc_req_valid, dc_req_type, dc_req_datatype, dc_req_paddr, dc_req_wrdata,
      output dc_req_rdabort, arb_gnt_id
   );
endinterface

// File: rtl/dcache_rr_arbiter.sv
// N-port round-robin arbiter in front of the single DCache request port, with per-port
// pending tracking, registered grant fields, read abort and an optional write-priority mode.
module dcache_rr_arbiter #(
   parameter int NUM_PORTS     = 4,
   parameter int PADDR_W       = 56,
   parameter int DATA_W        = 64,
   parameter int DT_W          = 3,
   parameter int WR_PRIO       = 0,
   parameter int MAX_WR_STREAK = 4
) (
   input logic                clk,
   input logic                rst,
   dcache_rr_arbiter_if.slave bus
);
   localparam int GW = $clog2(NUM_PORTS);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t               state_reg, state_next;
   logic [NUM_PORTS-1:0] pending_reg, pending_next;
   logic [GW-1:0]        last_gnt_reg, last_gnt_next;
   logic [GW-1:0]        gnt_id_reg;
   logic [3:0]           wr_streak_reg, wr_streak_next;
   logic                 type_reg;
   logic [DT_W-1:0]      datatype_reg;
   logic [PADDR_W-1:0]   paddr_reg;
   logic [DATA_W-1:0]    wrdata_reg;

   logic [NUM_PORTS-1:0] req, rd_abort, gnt_onehot;
   logic [GW:0]          pick_all, pick_wr, pick_rd, pick_sel;
   logic [GW-1:0]        pick_id;
   logic                 rd_pending, grant, done_hit, abort_hit;

   // Returns {found, id} of the first set bit of mask, searching from last+1 with wrap.
   function automatic logic [GW:0] rr_pick(input logic [NUM_PORTS-1:0] mask,
                                           input logic [GW-1:0] last);
      logic [GW:0] sel;
      sel = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         if (mask[(int'(last) + k) % NUM_PORTS])
            sel = {1'b1, GW'((int'(last) + k) % NUM_PORTS)};
      end
      return sel;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign rd_abort[gi]   = bus.port_abort[gi] & ~bus.port_wr[gi];
         assign req[gi]        = (bus.port_valid[gi] | pending_reg[gi]) & ~rd_abort[gi];
         assign gnt_onehot[gi] = (gnt_id_reg == GW'(gi));
      end
   endgenerate

   assign rd_pending = |(req & ~bus.port_wr);
   assign pick_all   = rr_pick(req, last_gnt_reg);
   assign pick_wr    = rr_pick(req & bus.port_wr, last_gnt_reg);
   assign pick_rd    = rr_pick(req & ~bus.port_wr, last_gnt_reg);

   // A full write streak hands the next slot to a waiting read.
   always_comb begin
      pick_sel = pick_all;
      if (WR_PRIO != 0) begin
         if (wr_streak_reg == 4'(MAX_WR_STREAK) && pick_rd[GW])
            pick_sel = pick_rd;
         else if (pick_wr[GW])
            pick_sel = pick_wr;
         else
            pick_sel = pick_rd;
      end
   end

   assign pick_id = pick_sel[GW-1:0];

   always_comb begin
      state_next    = state_reg;
      last_gnt_next = last_gnt_reg;
      grant         = 1'b0;
      done_hit      = 1'b0;
      abort_hit     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.dc_resp_ready && pick_sel[GW]) begin
               grant      = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (bus.dc_resp_done) begin
               done_hit      = 1'b1;
               state_next    = IDLE;
               last_gnt_next = gnt_id_reg;
            end else if (!type_reg && bus.port_abort[gnt_id_reg]) begin
               abort_hit     = 1'b1;
               state_next    = IDLE;
               last_gnt_next = gnt_id_reg;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Clears win over a valid still held on the completing cycle.
   always_comb begin
      pending_next = (pending_reg | (bus.port_valid & ~rd_abort)) & ~rd_abort
                     & ~(done_hit ? gnt_onehot : '0);
      wr_streak_next = wr_streak_reg;
      if (grant) begin
         if (bus.port_wr[pick_id] && rd_pending)
            wr_streak_next = (wr_streak_reg == 4'hF) ? 4'hF : wr_streak_reg + 4'd1;
         else
            wr_streak_next = '0;
      end else if (!rd_pending) begin
         wr_streak_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         pending_reg   <= '0;
         wr_streak_reg <= '0;
         last_gnt_reg  <= GW'(NUM_PORTS - 1);
         gnt_id_reg    <= '0;
         type_reg      <= 1'b0;
         datatype_reg  <= '0;
         paddr_reg     <= '0;
         wrdata_reg    <= '0;
      end else begin
         state_reg     <= state_next;
         pending_reg   <= pending_next;
         wr_streak_reg <= wr_streak_next;
         last_gnt_reg  <= last_gnt_next;
         if (grant) begin
            gnt_id_reg   <= pick_id;
            type_reg     <= bus.port_wr[pick_id];
            datatype_reg <= bus.port_datatype[pick_id*DT_W +: DT_W];
            paddr_reg    <= bus.port_paddr[pick_id*PADDR_W +: PADDR_W];
            wrdata_reg   <= bus.port_wrdata[pick_id*DATA_W +: DATA_W];
         end
      end
   end

   assign bus.port_done       = (done_hit && !rst) ? gnt_onehot : '0;
   assign bus.dc_req_rdabort  = abort_hit && !rst;
   assign bus.port_ready      = {NUM_PORTS{bus.dc_resp_ready}};
   assign bus.port_rddata     = bus.dc_resp_rddata;
   assign bus.dc_req_valid    = (state_reg == BUSY);
   assign bus.dc_req_type     = type_reg;
   assign bus.dc_req_datatype = datatype_reg;
   assign bus.dc_req_paddr    = paddr_reg;
   assign bus.dc_req_wrdata   = wrdata_reg;
   assign bus.arb_gnt_id      = gnt_id_reg;
endmodule

// File: tb/tb_dcache_rr_arbiter.sv
// Randomized bench for dcache_rr_arbiter: one pure round-robin and one write-priority
// instance, each driven by random requesters and a random DCache and checked against a model.
module tb_dcache_rr_arbiter;
   localparam int NP   = 4;
   localparam int PW   = 56;
   localparam int DW   = 64;
   localparam int TW   = 3;
   localparam int MAXS = 4;
   localparam int NCYC = 1500;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit fin [2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Ordered candidate list from the arbitration rules; first entry wins.
   function automatic int model_pick(input bit [NP-1:0] elig, input bit [NP-1:0] is_wr,
                                     input int last, input int streak, input bit wp);
      int order[$];
      bit reads_first;
      bit want_wr;
      reads_first = wp && (streak == MAXS) && ((elig & ~is_wr) != 0);
      for (int pass = 0; pass < 2; pass++) begin
         for (int k = 1; k <= NP; k++) begin
            int p;
            p = (last + k) % NP;
            if (!elig[p]) continue;
            if (!wp) begin
               if (pass == 0) order.push_back(p);
            end else begin
               want_wr = reads_first ? (pass == 1) : (pass == 0);
               if (is_wr[p] == want_wr) order.push_back(p);
            end
         end
      end
      return (order.size() > 0) ? order[0] : -1;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cfg
         localparam bit WP = (gi == 1);
         logic rst = 1'b1;

         dcache_rr_arbiter_if #(.NUM_PORTS(NP), .PADDR_W(PW), .DATA_W(DW), .DT_W(TW)) bus ();

         dcache_rr_arbiter #(
            .NUM_PORTS(NP), .PADDR_W(PW), .DATA_W(DW), .DT_W(TW),
            .WR_PRIO(gi), .MAX_WR_STREAK(MAXS)
         ) dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
         );

         bit act [NP];
         bit pulse [NP];
         bit first [NP];
         bit r_wr [NP];
         logic [PW-1:0] r_addr [NP];
         logic [DW-1:0] r_data [NP];
         logic [TW-1:0] r_dt [NP];
         bit [NP-1:0]   v_drv, a_drv, w_drv;
         bit            done_drv, ready_drv;
         logic [DW-1:0] rd_drv;

         bit            m_busy, m_type;
         int            m_gnt, m_last, m_streak;
         bit [NP-1:0]   m_pend;
         logic [PW-1:0] m_addr;
         logic [DW-1:0] m_data;
         logic [TW-1:0] m_dt;
         int            busy_k, done_at;
         bit            mid_rst_done, start_all, chk_zero;

         initial begin : run
            string pfx;
            bit [NP-1:0] rdab, elig;
            logic [NP-1:0] exp_done;
            bit rd_pend, granted, exp_ab;
            int g;
            pfx = WP ? "prio" : "rr";
            m_busy = 0; m_pend = '0; m_streak = 0; m_last = NP - 1; m_gnt = 0;
            busy_k = 0; done_at = 1; rd_drv = '0; done_drv = 0; ready_drv = 0;
            mid_rst_done = 0; start_all = 1; chk_zero = 0;
            for (int p = 0; p < NP; p++) begin
               act[p] = 0; pulse[p] = 0; first[p] = 0; r_wr[p] = 0;
               r_addr[p] = '0; r_data[p] = '0; r_dt[p] = '0;
            end
            for (int cyc = 0; cyc < NCYC; cyc++) begin
               @(posedge clk);
               #1;
               rst = (cyc < 2) || (!mid_rst_done && cyc > NCYC / 2 && m_busy && m_type);
               if (rst && cyc >= 2) mid_rst_done = 1;
               v_drv = '0;
               a_drv = '0;
               if (rst) begin
                  for (int p = 0; p < NP; p++) act[p] = 0;
                  start_all = 1;
                  done_drv = 0;
                  ready_drv = 0;
               end else begin
                  for (int p = 0; p < NP; p++) begin
                     if (!act[p]) begin
                        if (start_all || $urandom_range(0, 3) == 0) begin
                           act[p]    = 1;
                           first[p]  = 1;
                           r_wr[p]   = start_all ? 1'b0 :
                                       (WP ? ($urandom_range(0, 2) != 0) : bit'($urandom_range(0, 1)));
                           pulse[p]  = ($urandom_range(0, 3) == 0);
                           r_addr[p] = PW'({$urandom(), $urandom()});
                           r_data[p] = {$urandom(), $urandom()};
                           r_dt[p]   = TW'($urandom());
                        end
                     end else begin
                        first[p] = 0;
                        if ($urandom_range(0, 15) == 0) a_drv[p] = 1;
                     end
                     v_drv[p] = act[p] && (first[p] || !pulse[p]);
                     w_drv[p] = r_wr[p];
                  end
                  start_all = 0;
                  ready_drv = ($urandom_range(0, 5) != 0);
                  if (m_busy) busy_k++;
                  done_drv = m_busy && (busy_k >= done_at);
                  rd_drv = ($urandom_range(0, 1) != 0) ? 64'hDEADBEEF_00C0FFEE : {$urandom(), $urandom()};
               end
               bus.port_valid     = v_drv;
               bus.port_abort     = a_drv;
               bus.port_wr        = w_drv;
               for (int p = 0; p < NP; p++) begin
                  bus.port_paddr[p*PW +: PW]    = r_addr[p];
                  bus.port_wrdata[p*DW +: DW]   = r_data[p];
                  bus.port_datatype[p*TW +: TW] = r_dt[p];
               end
               bus.dc_resp_done   = done_drv;
               bus.dc_resp_ready  = ready_drv;
               bus.dc_resp_rddata = rd_drv;

               @(negedge clk);
               exp_done = (!rst && m_busy && done_drv) ? (NP'(1) << m_gnt) : '0;
               exp_ab   = !rst && m_busy && !done_drv && !m_type && a_drv[m_gnt];
               check({pfx, " dc_req_valid"}, 64'(bus.dc_req_valid), 64'(m_busy));
               check({pfx, " port_done"}, 64'(bus.port_done), 64'(exp_done));
               check({pfx, " dc_req_rdabort"}, 64'(bus.dc_req_rdabort), 64'(exp_ab));
               check({pfx, " port_ready"}, 64'(bus.port_ready), 64'({NP{ready_drv}}));
               check({pfx, " port_rddata"}, 64'(bus.port_rddata), 64'(rd_drv));
               if (m_busy) begin
                  check({pfx, " arb_gnt_id"}, 64'(bus.arb_gnt_id), 64'(m_gnt));
                  check({pfx, " dc_req_type"}, 64'(bus.dc_req_type), 64'(m_type));
                  check({pfx, " dc_req_paddr"}, 64'(bus.dc_req_paddr), 64'(m_addr));
                  check({pfx, " dc_req_datatype"}, 64'(bus.dc_req_datatype), 64'(m_dt));
                  if (m_type) check({pfx, " dc_req_wrdata"}, 64'(bus.dc_req_wrdata), 64'(m_data));
               end
               if (chk_zero) begin
                  check({pfx, " reset gnt_id"}, 64'(bus.arb_gnt_id), 64'd0);
                  check({pfx, " reset paddr"}, 64'(bus.dc_req_paddr), 64'd0);
                  check({pfx, " reset wrdata"}, 64'(bus.dc_req_wrdata), 64'd0);
                  chk_zero = 0;
               end

               if (rst) begin
                  m_busy = 0; m_pend = '0; m_streak = 0; m_last = NP - 1; m_gnt = 0;
                  chk_zero = 1;
               end else begin
                  rdab    = a_drv & ~w_drv;
                  elig    = (v_drv | m_pend) & ~rdab;
                  rd_pend = ((elig & ~w_drv) != 0);
                  m_pend  = (m_pend | (v_drv & ~rdab)) & ~rdab;
                  granted = 0;
                  if (m_busy) begin
                     if (done_drv) begin
                        $display("[%s] port %0d %s addr %0h done", pfx, m_gnt, m_type ? "wr" : "rd", m_addr);
                        m_pend[m_gnt] = 0;
                        act[m_gnt] = 0;
                        m_busy = 0;
                        m_last = m_gnt;
                     end else if (exp_ab) begin
                        $display("[%s] port %0d rd addr %0h aborted", pfx, m_gnt, m_addr);
                        m_busy = 0;
                        m_last = m_gnt;
                     end
                  end else if (ready_drv && elig != 0) begin
                     g        = model_pick(elig, w_drv, m_last, m_streak, WP);
                     m_busy   = 1;
                     m_gnt    = g;
                     m_type   = w_drv[g];
                     m_addr   = r_addr[g];
                     m_data   = r_data[g];
                     m_dt     = r_dt[g];
                     busy_k   = 0;
                     done_at  = $urandom_range(1, 4);
                     m_streak = !w_drv[g] ? 0 : (rd_pend ? ((m_streak == 15) ? 15 : m_streak + 1) : 0);
                     granted  = 1;
                  end
                  if (!granted && !rd_pend) m_streak = 0;
                  for (int p = 0; p < NP; p++) if (rdab[p]) act[p] = 0;
               end
            end
            fin[gi] = 1'b1;
         end
      end
   endgenerate

   initial begin
      repeat (NCYC + 20) @(posedge clk);
      if (!(fin[0] && fin[1])) begin
         n_checks++;
         n_fail++;
         $display("FAIL harness completion: got %0d%0d, expected 11", fin[0], fin[1]);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
